serial_bus_arbiter: RTL
=======================

SERIAL_BUS_ARBITER -- requirements
Module: serial_bus_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYC, default 10'd512, SHALL set the grant-to-first-valid_s timeout in clk cycles.
REQ-002 Parameter NUM_SLAVES, default 3, SHALL set the number of addressable slaves; slave code 2'b11 is reserved.
REQ-003 clk  input  1  bus clock; all logic on posedge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 m_req  input  2  per-master bus request; bit i belongs to master i.
REQ-006 m_valid_s  input  2  per-master frame-valid; the master is shifting address/data while high.
REQ-007 m_addr_tx  input  2  per-master serial address line, MSB first.
REQ-008 m_grant  output  2  one-hot grant, used as the master's bus_ready.
REQ-009 slv_sel  output  3  one-hot slave select.
REQ-010 slv_valid  output  1  granted master's m_valid_s, forwarded while connected.
REQ-011 cur_master  output  1  index of the granted master; valid only while busy=1.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 err  output  1  one-cycle pulse on decode error or timeout.

Function
REQ-014 The FSM SHALL have the states IDLE, GRANT, ADDR0, ADDR1, CONNECT and RELEASE.
REQ-015 IDLE: if any m_req bit is high, the FSM SHALL register m_grant and cur_master and enter GRANT on the next edge; grant latency is 1 cycle.
REQ-016 When both requests are high in IDLE, the master not equal to last_grant SHALL win; last_grant resets to 1, so master 0 wins first.
REQ-017 GRANT: when m_valid_s[cur_master] is high, the FSM SHALL sample m_addr_tx[cur_master] as code bit1 and go to ADDR1.
REQ-018 ADDR1: the FSM SHALL sample code bit0 and, on the same edge, decode the 2-bit code.
- Codes 0..NUM_SLAVES-1 go to CONNECT with slv_sel one-hot.
- Code 3 (or a code >= NUM_SLAVES) pulses err and goes to RELEASE.
REQ-019 CONNECT: slv_valid SHALL equal m_valid_s[cur_master] combinationally; slv_valid SHALL be 0 in all other states.
REQ-020 m_req[cur_master] falling in GRANT, ADDR1 or CONNECT SHALL cause the FSM to go to RELEASE on the next edge.
REQ-021 RELEASE: the FSM SHALL hold m_grant=0 and slv_sel=0 for exactly one cycle, update last_grant to cur_master, and return to IDLE.
REQ-022 A request from the non-granted master SHALL be ignored until IDLE; there is no pre-emption.
REQ-023 m_grant SHALL be high only in GRANT, ADDR0, ADDR1 and CONNECT, and SHALL never have two bits set.
REQ-024 State ADDR0 is reserved for future multi-bit decode; it SHALL be entered from no state and SHALL transition to RELEASE if reached.
REQ-025 m_valid_s falling in ADDR1 SHALL abort the frame: pulse err and go to RELEASE.
REQ-026 A new request may be granted in the cycle after RELEASE, giving a minimum 2-cycle gap between grants.

Reset
REQ-027 When reset is high at a clk edge, the block SHALL go to IDLE and clear m_grant, slv_sel, slv_valid, busy, err and cur_master to 0, and set last_grant to 1.
REQ-028 Reset in any state, including CONNECT, SHALL drop all outputs on that edge without passing through RELEASE.

Configuration
REQ-029 With macro ARB_TIMEOUT_EN defined:
- A 10-bit counter SHALL clear on entry to GRANT and increment each cycle in GRANT.
- When it reaches TIMEOUT_CYC-1 with no valid_s, the block SHALL pulse err and go to RELEASE.
REQ-030 Without ARB_TIMEOUT_EN, the counter SHALL be absent and GRANT SHALL wait indefinitely.

Structure
REQ-031 The state encoding (5-bit localparams), the slave code constants, and the value NUM_MASTERS=2 SHALL live in shared package bus_pkg.
REQ-032 The winner selection (request vector + last_grant -> one-hot grant) SHALL be sub-module rr_pick2; everything else is flat.

Verification
REQ-033 Scenario: reset, then m_req=01 -> m_grant=01 one cycle later, busy=1, cur_master=0.
REQ-034 Scenario: m_req=11 from reset -> master 0 is granted; after master 0 drops req, RELEASE, then m_grant=10 two cycles after the drop.
REQ-035 Scenario: granted master 1 asserts valid_s with address bits 1,0 -> slv_sel=100 at the edge after bit0; slv_valid tracks m_valid_s[1].
REQ-036 Scenario: address bits 1,1 -> err pulses for 1 cycle, m_grant=00 the next cycle, slv_sel stays 000.
REQ-037 Scenario: with ARB_TIMEOUT_EN and TIMEOUT_CYC=8, the grant is held without valid_s -> err and release after exactly 8 GRANT cycles.
REQ-038 Scenario: reset asserted during CONNECT -> all outputs 0 on that edge; the next request is granted to master 0.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared definitions for the serial bus arbiter: state encoding, slave
// address codes and the fixed master count.
package bus_pkg;

    localparam int NUM_MASTERS = 2;

    // Binary state encoding, 5 bits wide to leave room for future states
    localparam logic [4:0] ST_IDLE    = 5'd0;
    localparam logic [4:0] ST_GRANT   = 5'd1;
    localparam logic [4:0] ST_ADDR0   = 5'd2;
    localparam logic [4:0] ST_ADDR1   = 5'd3;
    localparam logic [4:0] ST_CONNECT = 5'd4;
    localparam logic [4:0] ST_RELEASE = 5'd5;

    typedef enum logic [4:0] {
        IDLE    = ST_IDLE,
        GRANT   = ST_GRANT,
        ADDR0   = ST_ADDR0,
        ADDR1   = ST_ADDR1,
        CONNECT = ST_CONNECT,
        RELEASE = ST_RELEASE
    } state_t;

    // Two-bit slave address codes shifted in by the master, MSB first
    localparam logic [1:0] SLV_CODE_0    = 2'b00;
    localparam logic [1:0] SLV_CODE_1    = 2'b01;
    localparam logic [1:0] SLV_CODE_2    = 2'b10;
    localparam logic [1:0] SLV_CODE_RSVD = 2'b11;

    // Map a slave code to its one-hot select; the reserved code selects nothing
    function automatic logic [2:0] slv_onehot(input logic [1:0] code);
        logic [2:0] sel;
        case (code)
            SLV_CODE_0: sel = 3'b001;
            SLV_CODE_1: sel = 3'b010;
            SLV_CODE_2: sel = 3'b100;
            default:    sel = 3'b000;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-master round-robin winner selection: turns the request vector and the
// index of the last granted master into a one-hot grant.
module rr_pick2
    import bus_pkg::*;
(
    input  logic [NUM_MASTERS-1:0] i_req,
    input  logic                   i_last,
    output logic [NUM_MASTERS-1:0] o_grant
);

    // A lone requester always wins; on contention the master that did not go last wins
    always_comb begin
        o_grant = '0;
        case (i_req)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            2'b11:   o_grant = i_last ? 2'b01 : 2'b10;
            default: o_grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/serial_bus_arbiter.sv
// Serial bus arbiter: grants one of two masters, shifts in a 2-bit slave
// address, connects the master to the decoded slave and releases the bus
// when the master drops its request.
// Optional feature: define ARB_TIMEOUT_EN to release a grant whose master
// never starts a frame within TIMEOUT_CYC cycles.
module serial_bus_arbiter
    import bus_pkg::*;
#(
    parameter logic [9:0] TIMEOUT_CYC = 10'd512,
    parameter int         NUM_SLAVES  = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_MASTERS-1:0] m_req,
    input  logic [NUM_MASTERS-1:0] m_valid_s,
    input  logic [NUM_MASTERS-1:0] m_addr_tx,
    output logic [NUM_MASTERS-1:0] m_grant,
    output logic [2:0]             slv_sel,
    output logic                   slv_valid,
    output logic                   cur_master,
    output logic                   busy,
    output logic                   err
);

    state_t                 r_state, w_state_nxt;
    logic [NUM_MASTERS-1:0] r_grant, w_grant_nxt;
    logic [2:0]             r_slv_sel, w_slv_sel_nxt;
    logic                   r_cur, w_cur_nxt;
    logic                   r_last, w_last_nxt;
    logic                   r_bit1, w_bit1_nxt;
    logic                   r_err, w_err_nxt;

    logic [NUM_MASTERS-1:0] w_pick;
    logic                   w_req_cur;
    logic                   w_valid_cur;
    logic                   w_addr_cur;
    logic [1:0]             w_code;
    logic                   w_code_ok;

    rr_pick2 u_pick (
        .i_req   (m_req),
        .i_last  (r_last),
        .o_grant (w_pick)
    );

    // Signals of the currently granted master and the address being decoded
    assign w_req_cur   = m_req[r_cur];
    assign w_valid_cur = m_valid_s[r_cur];
    assign w_addr_cur  = m_addr_tx[r_cur];
    assign w_code      = {r_bit1, w_addr_cur};
    assign w_code_ok   = (w_code != SLV_CODE_RSVD) && (int'(w_code) < NUM_SLAVES);

`ifdef ARB_TIMEOUT_EN
    logic [9:0] r_tmo_cnt;
    logic       w_timeout;

    assign w_timeout = (r_tmo_cnt == TIMEOUT_CYC - 10'd1);

    // Count cycles spent in GRANT; held at zero elsewhere so it restarts on entry
    always_ff @(posedge clk) begin
        if (reset || (r_state != GRANT)) begin
            r_tmo_cnt <= '0;
        end else begin
            r_tmo_cnt <= r_tmo_cnt + 10'd1;
        end
    end
`endif

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_grant   <= '0;
            r_slv_sel <= '0;
            r_cur     <= 1'b0;
            r_last    <= 1'b1;
            r_bit1    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_grant   <= w_grant_nxt;
            r_slv_sel <= w_slv_sel_nxt;
            r_cur     <= w_cur_nxt;
            r_last    <= w_last_nxt;
            r_bit1    <= w_bit1_nxt;
            r_err     <= w_err_nxt;
        end
    end

    // Next-state and next-output decode
    always_comb begin
        w_state_nxt   = r_state;
        w_grant_nxt   = r_grant;
        w_slv_sel_nxt = r_slv_sel;
        w_cur_nxt     = r_cur;
        w_last_nxt    = r_last;
        w_bit1_nxt    = r_bit1;
        w_err_nxt     = 1'b0;

        case (r_state)
            IDLE: begin
                if (|m_req) begin
                    w_state_nxt = GRANT;
                    w_grant_nxt = w_pick;
                    w_cur_nxt   = w_pick[1];
                end
            end
            GRANT: begin
                if (!w_req_cur) begin
                    w_state_nxt = RELEASE;
                end else if (w_valid_cur) begin
                    w_bit1_nxt  = w_addr_cur;
                    w_state_nxt = ADDR1;
                end
`ifdef ARB_TIMEOUT_EN
                else if (w_timeout) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = RELEASE;
                end
`endif
            end
            ADDR1: begin
                if (!w_req_cur) begin
                    w_state_nxt = RELEASE;
                end else if (!w_valid_cur) begin
                    // Master abandoned the frame mid-address
                    w_err_nxt   = 1'b1;
                    w_state_nxt = RELEASE;
                end else if (w_code_ok) begin
                    w_slv_sel_nxt = slv_onehot(w_code);
                    w_state_nxt   = CONNECT;
                end else begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = RELEASE;
                end
            end
            CONNECT: begin
                if (!w_req_cur) begin
                    w_state_nxt = RELEASE;
                end
            end
            RELEASE: begin
                w_last_nxt  = r_cur;
                w_state_nxt = IDLE;
            end
            default: begin
                // ADDR0 is reserved and unreachable; bail out cleanly if ever hit
                w_state_nxt = RELEASE;
            end
        endcase

        // The bus is fully disconnected for the whole RELEASE cycle
        if (w_state_nxt == RELEASE) begin
            w_grant_nxt   = '0;
            w_slv_sel_nxt = '0;
        end
    end

    assign m_grant    = r_grant;
    assign slv_sel    = r_slv_sel;
    assign cur_master = r_cur;
    assign busy       = (r_state != IDLE);
    assign err        = r_err;
    assign slv_valid  = (r_state == CONNECT) && w_valid_cur;

endmodule
